axil_csr_slave: RTL and testbench
=================================

Name: axil_csr_slave

Overview:
AXI-Lite slave register file that sits directly downstream of the Ibex device-side AXI-Lite master bridge. It terminates single-beat AXI-Lite reads and writes into a bank of 32-bit control/status registers. Control fields drive accelerator logic; status words are read back from that logic. It serves one outstanding write and one outstanding read, and the two channels run independently.

Parameters:
AXI_ADDR_WIDTH, 32, AXI-Lite address width.
AXI_DATA_WIDTH, 32, data width; must be 32.
N_REGS, 16, number of 32-bit registers; power of two, 2..256.
BASE_ADDR, 32'h0, byte address of register 0; aligned to N_REGS*4.
RO_MASK, '0 (N_REGS bits), bit i=1 makes register i read-only status.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  AXI_ADDR_WIDTH  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  AXI_ADDR_WIDTH  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read valid
S_AXI_RREADY  in  1  read ready
csr_q  out  N_REGS*32  flattened RW register contents; register i is at [32*i+:32]
csr_wr_o  out  N_REGS  one-cycle pulse per register on a successful write
status_i  in  N_REGS*32  status words returned for RO registers

Behaviour:
- Reset (async, rst_n=0): all registers 0, csr_wr_o=0, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0. AWREADY, WREADY and ARREADY are 1, because all buffers are empty.
- Write address buffer: one entry. AWREADY = !aw_full. An AW handshake captures AWADDR and sets aw_full.
- Write data buffer: one entry. WREADY = !w_full. A W handshake captures WDATA and WSTRB and sets w_full.
- AW and W may arrive in any order or in the same cycle. VALID dropping in the cycle after its handshake is legal.
- Commit: at a clock edge where aw_full & w_full & !BVALID:
  - decode the write, update the register, clear both buffers;
  - set BVALID=1 and pulse csr_wr_o[idx] for exactly the following cycle (successful writes only).
- Minimum write latency: AW and W handshakes at edge N, commit at edge N+1, BVALID high from N+1.
- Write response hold: BVALID and BRESP hold until BVALID&BREADY. While BVALID=1, a new AW/W pair may be buffered but is not committed. It commits at the edge after the B handshake.
- Decode: off = addr - BASE_ADDR. addr[1:0] is ignored. idx = off[$clog2(N_REGS)+1:2]. out_of_range = (off >= N_REGS*4), compared on the full address width; addresses below BASE_ADDR wrap and count as out of range.
- Write rules:
  - In range and RO_MASK[idx]=0: byte lane b updates only if WSTRB[b]; BRESP=OKAY (2'b00).
  - WSTRB=0: BRESP=OKAY, no change, csr_wr_o still pulses.
  - Out of range, or RO register: no update, no csr_wr_o pulse, BRESP=SLVERR (2'b10).
- Read: ARREADY = !RVALID. On an AR handshake at edge N, RDATA and RRESP are registered and RVALID=1 from N+1. They hold until RVALID&RREADY, and ARREADY rises the cycle after. Maximum throughput is one read per 2 cycles.
- Read data:
  - RW register: csr_q word; RRESP=OKAY.
  - RO register: status_i word sampled at the AR edge; RRESP=OKAY.
  - Out of range: RDATA=0, RRESP=SLVERR.
- Simultaneous read and write commit to the same register on the same edge: the read returns the pre-write value.
- RO registers: csr_q slice is held 0.
- Reset mid-transaction: buffers and pending responses are discarded; no response is generated for in-flight requests.

Test Plan:
- Write 0xDEADBEEF to BASE+0x8, AW and W in the same cycle, WSTRB=4'hF, BREADY=1 -> BVALID at edge+1, BRESP=00, csr_wr_o[2] pulses 1 cycle, csr_q[95:64]=0xDEADBEEF; a following read of 0x8 returns 0xDEADBEEF, RRESP=00.
- W 3 cycles before AW, WDATA=0x11223344, WSTRB=4'b0101, to register 1 previously 0xFFFFFFFF -> commit 1 cycle after AW; register 1 = 0xFF22FF44.
- Write to BASE+N_REGS*4 (0x40 at default) -> BRESP=10, no csr_wr_o pulse, csr_q unchanged; read of 0x40 -> RDATA=0, RRESP=10.
- RO_MASK[3]=1, status_i word 3 = 0xCAFE0003 -> read of 0xC returns 0xCAFE0003, RRESP=00; write to 0xC -> BRESP=10, no change.
- BREADY held 0 for 5 cycles with a second AW/W pair offered -> second pair buffered, AWREADY/WREADY=0 afterwards, commit only at the edge after the B handshake; RREADY=0 for 4 cycles -> RVALID/RDATA stable, ARREADY=0.
- Assert rst_n=0 with aw_full=1 and RVALID=1 -> all outputs return to reset values immediately; after release there is no spurious BVALID or csr_wr_o.

Source files
------------

// File: rtl/axil_csr_slave_if.sv
// AXI-Lite bus bundle between the device-side master bridge and the CSR slave.
// valid/ready: a beat transfers on a rising clk edge where both are high; valid never waits on ready.
interface axil_csr_slave_if #(
  parameter int AXI_ADDR_WIDTH = 32
) ();
  logic [AXI_ADDR_WIDTH-1:0] awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [31:0]               wdata;
  logic [3:0]                wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic                      arvalid;
  logic                      arready;
  logic [31:0]               rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_csr_slave.sv
// AXI-Lite CSR register file: one-entry AW/W buffers, independent read channel,
// RW control registers with per-register write pulses and RO status pass-through.
module axil_csr_slave #(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        N_REGS         = 16,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [N_REGS-1:0]         RO_MASK        = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axil_csr_slave_if.slave      s_axi,
  output logic [N_REGS*32-1:0] csr_q,
  output logic [N_REGS-1:0]    csr_wr_o,
  input  logic [N_REGS*32-1:0] status_i
);
  localparam int                        IDX_W       = $clog2(N_REGS);
  localparam logic [AXI_ADDR_WIDTH-1:0] SPAN        = AXI_ADDR_WIDTH'(N_REGS * 4);
  localparam logic [1:0]                RESP_OKAY   = 2'b00;
  localparam logic [1:0]                RESP_SLVERR = 2'b10;

  if (AXI_DATA_WIDTH != 32) begin : g_bad_width
    $error("axil_csr_slave only supports a 32-bit data bus");
  end

  logic                      aw_full_q, w_full_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]               wdata_q;
  logic [3:0]                wstrb_q;
  logic                      bvalid_q, rvalid_q;
  logic [1:0]                bresp_q, rresp_q;
  logic [31:0]               rdata_q;
  logic [31:0]               regs_q [N_REGS];
  logic [N_REGS-1:0]         csr_wr_q;

  logic [31:0]               status_w [N_REGS];
  logic [AXI_ADDR_WIDTH-1:0] aw_off, ar_off;
  logic [IDX_W-1:0]          aw_idx, ar_idx;
  logic                      aw_in_range, ar_in_range;
  logic                      wr_ok, commit, aw_hs, w_hs, ar_hs;
  logic [31:0]               rd_word;

  // Addresses below BASE_ADDR wrap to a large offset and fall out of range.
  assign aw_off      = awaddr_q - BASE_ADDR;
  assign ar_off      = s_axi.araddr - BASE_ADDR;
  assign aw_idx      = aw_off[IDX_W+1:2];
  assign ar_idx      = ar_off[IDX_W+1:2];
  assign aw_in_range = aw_off < SPAN;
  assign ar_in_range = ar_off < SPAN;

  assign wr_ok  = aw_in_range & ~RO_MASK[aw_idx];
  assign commit = aw_full_q & w_full_q & ~bvalid_q;
  assign aw_hs  = s_axi.awvalid & ~aw_full_q;
  assign w_hs   = s_axi.wvalid & ~w_full_q;
  assign ar_hs  = s_axi.arvalid & ~rvalid_q;

  assign s_axi.awready = ~aw_full_q;
  assign s_axi.wready  = ~w_full_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = ~rvalid_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign csr_wr_o      = csr_wr_q;

  always_comb begin
    csr_q = '0;
    for (int i = 0; i < N_REGS; i++) begin
      status_w[i]       = status_i[32*i +: 32];
      csr_q[32*i +: 32] = RO_MASK[i] ? 32'h0 : regs_q[i];
    end
  end

  always_comb begin
    rd_word = '0;
    if (ar_in_range) begin
      rd_word = RO_MASK[ar_idx] ? status_w[ar_idx] : regs_q[ar_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      csr_wr_q  <= '0;
    end else begin
      csr_wr_q <= '0;
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        awaddr_q  <= s_axi.awaddr;
      end else if (commit) begin
        aw_full_q <= 1'b0;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        wdata_q  <= s_axi.wdata;
        wstrb_q  <= s_axi.wstrb;
      end else if (commit) begin
        w_full_q <= 1'b0;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) csr_wr_q[aw_idx] <= 1'b1;
      end else if (bvalid_q && s_axi.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
    end else if (commit && wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) regs_q[aw_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  // Read samples regs_q before any same-edge commit lands, so it sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_word;
      rresp_q  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axil_csr_slave.sv
// Directed bench for axil_csr_slave: a vector table of single transactions plus
// hand-written sequences for ordering, back-pressure, collision and reset cases.
module tb_axil_csr_slave;
  localparam int          N_REGS  = 16;
  localparam logic [15:0] RO_MASK = 16'h0008;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N_REGS*32-1:0] csr_q;
  logic [N_REGS*32-1:0] status_i;
  logic [N_REGS-1:0]    csr_wr_o;

  always #5 clk = ~clk;

  axil_csr_slave_if #(.AXI_ADDR_WIDTH(32)) bus ();

  axil_csr_slave #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .N_REGS(N_REGS),
    .BASE_ADDR(32'h0), .RO_MASK(RO_MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_axi(bus),
    .csr_q(csr_q), .csr_wr_o(csr_wr_o), .status_i(status_i)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic [15:0] exp_pulse;
    int          chk_idx;
    logic [31:0] chk_val;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [31:0] csr_word(input int idx);
    return csr_q[32*idx +: 32];
  endfunction

  task automatic bus_idle();
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;
  endtask

  // AW and W offered together; lat counts negedges from the handshake edge to BVALID.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [15:0] pulse, output int lat);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0; resp = 2'bxx; pulse = 'x;
    @(negedge clk);
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(posedge clk);
      @(negedge clk);
      if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_hs) begin w_done = 1; bus.wvalid = 1'b0; end
      n++;
    end
    if (!(aw_done && w_done)) fail_now("write_addr_data_handshake");
    lat = 1;
    while (!bus.bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.bvalid) fail_now("write_bvalid");
    resp  = bus.bresp;
    pulse = csr_wr_o;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    int n;
    n = 0; hs = 0; data = 'x; resp = 2'bxx;
    @(negedge clk);
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    while (!hs && n < 20) begin
      hs = bus.arready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    bus.arvalid = 1'b0;
    if (!hs) fail_now("read_addr_handshake");
    n = 0;
    while (!bus.rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rvalid) fail_now("read_rvalid");
    data = bus.rdata;
    resp = bus.rresp;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [15:0] pulse;
    logic [31:0] rdata;
    int          lat;

    vecs[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 16'h0004, 2, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 32'h08, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF, 16'h0, 0, 32'h0};
    vecs[2]  = '{1'b1, 32'h04, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0, 16'h0002, 1, 32'hFFFFFFFF};
    vecs[3]  = '{1'b1, 32'h40, 32'h12345678, 4'hF, 2'b10, 32'h0, 16'h0000, 0, 32'h0};
    vecs[4]  = '{1'b0, 32'h40, 32'h0, 4'h0, 2'b10, 32'h0, 16'h0, 0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0C, 32'h0, 4'h0, 2'b00, 32'hCAFE0003, 16'h0, 0, 32'h0};
    vecs[6]  = '{1'b1, 32'h0C, 32'h55555555, 4'hF, 2'b10, 32'h0, 16'h0000, 3, 32'h0};
    vecs[7]  = '{1'b0, 32'h0C, 32'h0, 4'h0, 2'b00, 32'hCAFE0003, 16'h0, 0, 32'h0};
    vecs[8]  = '{1'b1, 32'h08, 32'h00000000, 4'h0, 2'b00, 32'h0, 16'h0004, 2, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 32'h08, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF, 16'h0, 0, 32'h0};
    vecs[10] = '{1'b1, 32'h3F, 32'hA5A5A5A5, 4'hF, 2'b00, 32'h0, 16'h8000, 15, 32'hA5A5A5A5};
    vecs[11] = '{1'b0, 32'h3C, 32'h0, 4'h0, 2'b00, 32'hA5A5A5A5, 16'h0, 0, 32'h0};
    vecs[12] = '{1'b1, 32'h3C, 32'h00000000, 4'h8, 2'b00, 32'h0, 16'h8000, 15, 32'h00A5A5A5};
    vecs[13] = '{1'b0, 32'h3E, 32'h0, 4'h0, 2'b00, 32'h00A5A5A5, 16'h0, 0, 32'h0};
    vecs[14] = '{1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 2'b10, 32'h0, 16'h0, 0, 32'h0};
    vecs[15] = '{1'b1, 32'h00, 32'h00000001, 4'hF, 2'b00, 32'h0, 16'h0001, 0, 32'h00000001};

    bus_idle();
    status_i = '0;
    status_i[3*32 +: 32] = 32'hCAFE0003;
    status_i[2*32 +: 32] = 32'hBAD00002;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awready", bus.awready, 1'b1);
    check("rst_wready", bus.wready, 1'b1);
    check("rst_arready", bus.arready, 1'b1);
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_bresp_rresp", {bus.bresp, bus.rresp}, 4'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_csr_wr", csr_wr_o, 16'h0);
    check("rst_csr_q", csr_q, 512'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulse, lat);
        check($sformatf("v%0d_bresp", i), resp, vecs[i].exp_resp);
        check($sformatf("v%0d_wr_pulse", i), pulse, vecs[i].exp_pulse);
        check($sformatf("v%0d_latency", i), lat, 2);
        check($sformatf("v%0d_csr_word", i), csr_word(vecs[i].chk_idx), vecs[i].chk_val);
        check($sformatf("v%0d_pulse_end", i), csr_wr_o, 16'h0);
      end else begin
        exp_q.push_back(vecs[i].exp_rdata);
        do_read(vecs[i].addr, rdata, resp);
        check($sformatf("v%0d_rdata", i), rdata, exp_q.pop_front());
        check($sformatf("v%0d_rresp", i), resp, vecs[i].exp_resp);
      end
    end

    // W three cycles ahead of AW onto register 1 (0xFFFFFFFF).
    @(negedge clk);
    bus.wdata = 32'h11223344; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.wvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("wfirst_awready", bus.awready, 1'b1);
    check("wfirst_wready", bus.wready, 1'b0);
    check("wfirst_no_bvalid", bus.bvalid, 1'b0);
    bus.awaddr = 32'h04; bus.awvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.awvalid = 1'b0;
    check("wfirst_no_early_commit", bus.bvalid, 1'b0);
    @(negedge clk);
    check("wfirst_bvalid", bus.bvalid, 1'b1);
    check("wfirst_pulse", csr_wr_o, 16'h0002);
    check("wfirst_reg1", csr_word(1), 32'hFF22FF44);
    @(negedge clk);

    // Read of register 7 lands on the same edge as its write commit.
    bus.awaddr = 32'h1C; bus.awvalid = 1'b1;
    bus.wdata = 32'h77777777; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 32'h1C; bus.arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.arvalid = 1'b0;
    check("collide_rvalid", bus.rvalid, 1'b1);
    check("collide_old_value", bus.rdata, 32'h0);
    check("collide_bvalid", bus.bvalid, 1'b1);
    check("collide_reg7", csr_word(7), 32'h77777777);
    @(negedge clk);

    // Write response back-pressure with a second pair buffered behind it.
    bus.bready = 1'b0;
    bus.awaddr = 32'h14; bus.awvalid = 1'b1;
    bus.wdata = 32'h5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    check("bp_first_bvalid", bus.bvalid, 1'b1);
    check("bp_reg5", csr_word(5), 32'h5);
    bus.awaddr = 32'h18; bus.awvalid = 1'b1;
    bus.wdata = 32'h66; bus.wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("bp_buffered_ready", {bus.awready, bus.wready}, 2'b00);
    repeat (3) @(negedge clk);
    check("bp_hold_bvalid", bus.bvalid, 1'b1);
    check("bp_hold_bresp", bus.bresp, 2'b00);
    check("bp_no_commit", csr_word(6), 32'h0);
    check("bp_no_pulse", csr_wr_o, 16'h0);
    bus.bready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp_after_hs_bvalid", bus.bvalid, 1'b0);
    check("bp_after_hs_reg6", csr_word(6), 32'h0);
    @(negedge clk);
    check("bp_second_bvalid", bus.bvalid, 1'b1);
    check("bp_second_pulse", csr_wr_o, 16'h0040);
    check("bp_second_reg6", csr_word(6), 32'h66);
    @(negedge clk);

    // Read data back-pressure.
    bus.araddr = 32'h14; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.arvalid = 1'b0;
    check("rbp_rvalid", bus.rvalid, 1'b1);
    check("rbp_rdata", bus.rdata, 32'h5);
    repeat (3) @(negedge clk);
    check("rbp_hold", {bus.rvalid, bus.arready, bus.rdata}, {1'b1, 1'b0, 32'h5});
    bus.rready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rbp_released", {bus.rvalid, bus.arready}, 2'b01);

    // Reset with an AW buffered and a read response pending.
    bus.awaddr = 32'h20; bus.awvalid = 1'b1;
    bus.araddr = 32'h08; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    check("pre_rst_state", {bus.awready, bus.rvalid}, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check("mid_rst_valid", {bus.bvalid, bus.rvalid}, 2'b00);
    check("mid_rst_rdata", bus.rdata, 32'h0);
    check("mid_rst_csr_q", csr_q, 512'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_bvalid_%0d", k), bus.bvalid, 1'b0);
      check($sformatf("post_rst_pulse_%0d", k), csr_wr_o, 16'h0);
    end
    do_write(32'h08, 32'h12345678, 4'hF, resp, pulse, lat);
    check("post_rst_write_resp", resp, 2'b00);
    check("post_rst_write_pulse", pulse, 16'h0004);
    check("post_rst_write_reg2", csr_word(2), 32'h12345678);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
